// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register-file write-port arbiter for WB and multi-cycle results
//
// Shares the single register-file write port between WB-stage writes and
// buffered multi-cycle (mul/div) results. It keeps a pending scoreboard of
// registers with outstanding results and stalls ID on hazards or when the
// buffered head is starved by WB.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   wb_we, wb_rd, wb_wd           WB-stage write request (priority)
//   md_issue, md_issue_rd         multi-cycle op issued (marks rd pending)
//   md_valid, md_rd, md_wd        multi-cycle result; md_ready = FIFO not full
//   id_rs1, id_rs2                ID-stage source registers
//   stall                         RAW hazard on pending reg, or starved head
//   RegWrite, WR, WD              register-file write port
module rf_write_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_wd,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_rd,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_wd,
  output logic        md_ready,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  output logic        stall,
  output logic        RegWrite,
  output logic [4:0]  WR,
  output logic [31:0] WD
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [4:0]    fifo_rd [DEPTH];
  logic [31:0]   fifo_wd [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   pending;
  logic [31:0]   pending_nxt;
  logic [WW-1:0] wait_cnt;

  logic fifo_empty;
  logic wb_win;
  logic head_commit;
  logic push;

  assign fifo_empty  = (count == '0);
  // A write to x0 is treated as no request so the head can use the port.
  assign wb_win      = wb_we && (wb_rd != 5'd0);
  assign head_commit = !wb_win && !fifo_empty;
  // Readiness looks at the registered count only: a full FIFO refuses a
  // push even in a cycle where its head drains.
  assign md_ready    = (count != CW'(DEPTH));
  assign push        = md_valid && md_ready && (md_rd != 5'd0);

  always_comb begin
    RegWrite = 1'b0;
    WR       = 5'd0;
    WD       = 32'd0;
    if (wb_win) begin
      RegWrite = 1'b1;
      WR       = wb_rd;
      WD       = wb_wd;
    end else if (!fifo_empty) begin
      RegWrite = 1'b1;
      WR       = fifo_rd[head];
      WD       = fifo_wd[head];
    end
  end

  // Clear is applied first so a same-cycle re-issue of the committing
  // register keeps its pending bit.
  always_comb begin
    pending_nxt = pending;
    if (head_commit) begin
      pending_nxt[fifo_rd[head]] = 1'b0;
    end
    if (md_issue && (md_issue_rd != 5'd0)) begin
      pending_nxt[md_issue_rd] = 1'b1;
    end
  end

  assign stall = ((id_rs1 != 5'd0) && pending[id_rs1]) ||
                 ((id_rs2 != 5'd0) && pending[id_rs2]) ||
                 (wait_cnt == WW'(MAX_WAIT));

  // FIFO payload needs no reset: it is only visible when count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[tail] <= md_rd;
      fifo_wd[tail] <= md_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      pending  <= 32'd0;
      wait_cnt <= '0;
    end else begin
      pending <= pending_nxt;

      if (push) begin
        tail <= (tail == PW'(DEPTH - 1)) ? '0 : tail + 1'b1;
      end
      if (head_commit) begin
        head <= (head == PW'(DEPTH - 1)) ? '0 : head + 1'b1;
      end

      case ({push, head_commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (fifo_empty || head_commit) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WW'(MAX_WAIT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Every buffered result belongs to an issued op that is still pending.
  always @(posedge clk) begin
    if (!rst) begin
      assert ($countones(pending) >= int'(count));
      assert (!(push && (count == CW'(DEPTH))));
    end
  end

endmodule
